montinv_arb: RTL and testbench



---
 rtl/montinv_arb_pkg.sv | 16 +
 rtl/montinv_rrpick.sv | 34 +++
 rtl/montinv_arb.sv | 133 +++++++++++++
 tb/tb_montinv_arb.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/montinv_arb_pkg.sv
// Shared definitions for the montinv arbiter: FSM encoding and default sizes
// that must agree with the montinv datapath.
package montinv_arb_pkg;

  localparam int DEF_WIDTH = 256;
  localparam int DEF_LATW  = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

endpackage

// File: rtl/montinv_rrpick.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, searching upward and wrapping; indices >= NREQ never exist here.
module montinv_rrpick #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] idx,
  output logic            found
);

  // Two passes keep every select constant: first the upper segment
  // [ptr, NREQ), then the wrapped segment [0, ptr).
  always_comb begin
    // NOTE: every output gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    idx   = '0;
    found = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req[j] && (j >= int'(ptr))) begin
        found = 1'b1;
        idx   = IDXW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req[j] && (j < int'(ptr))) begin
        found = 1'b1;
        idx   = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/montinv_arb.sv
// Round-robin sequencer sharing one montinv instance among NREQ requesters:
// screens operands, launches the inverse, returns result and latency.
module montinv_arb
  import montinv_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = 4,
  parameter int IDXW  = 2,
  parameter int LATW  = DEF_LATW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*WIDTH-1:0] din,
  input  logic [WIDTH-1:0]     mod,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      err,
  output logic [WIDTH-1:0]     res,
  output logic                 busy,
  output logic [LATW-1:0]      lat,
  output logic [WIDTH-1:0]     inv_din,
  output logic [WIDTH-1:0]     inv_mod,
  output logic                 inv_en,
  input  logic [WIDTH-1:0]     inv_res,
  input  logic                 inv_vld
);

  state_t          state, state_nxt;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] pick_idx;
  logic            pick_found;
  logic [NREQ-1:0] pick_oh;
  logic [WIDTH-1:0] pick_op;
  logic [LATW-1:0] cnt;
  logic            illegal;

  montinv_rrpick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Operand mux and one-hot grant for the winner, built with constant selects.
  always_comb begin
    pick_op = '0;
    pick_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(pick_idx) == i) begin
        pick_op    = din[i*WIDTH +: WIDTH];
        pick_oh[i] = 1'b1;
      end
    end
  end

  assign illegal = (inv_din == '0) || (inv_din >= inv_mod);
  assign inv_en  = (state == ST_LAUNCH);
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (pick_found) state_nxt = ST_CHECK;
      ST_CHECK:  state_nxt = illegal ? ST_RESP : ST_LAUNCH;
      ST_LAUNCH: state_nxt = ST_WAIT;
      ST_WAIT:   if (inv_vld) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // inv_din/inv_mod are only rewritten in IDLE, so montinv sees them stable
  // for the whole operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt     <= '0;
      done    <= '0;
      err     <= '0;
      res     <= '0;
      lat     <= '0;
      inv_din <= '0;
      inv_mod <= '0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        ST_IDLE: begin
          gnt <= '0;
          if (pick_found) begin
            inv_din <= pick_op;
            inv_mod <= mod;
            gnt     <= pick_oh;
            ptr     <= (int'(pick_idx) == NREQ-1) ? '0 : pick_idx + 1'b1;
          end
        end
        ST_CHECK: begin
          if (illegal) err <= gnt;
        end
        ST_LAUNCH: begin
          cnt <= '0;
        end
        ST_WAIT: begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          if (inv_vld) begin
            res  <= inv_res;
            lat  <= (cnt == '1) ? cnt : cnt + 1'b1;
            done <= gnt;
          end
        end
        ST_RESP: begin
          gnt <= '0;
        end
        default: begin
          gnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_montinv_arb.sv
// Directed-plus-random bench for montinv_arb with an inline montinv model and
// a behavioural arbitration/latency reference.
module tb_montinv_arb;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int LW = 12;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [W-1:0]   op_v [N];
  logic [N*W-1:0] din;
  logic [W-1:0]   mod_r;
  logic [N-1:0]   gnt, done, err;
  logic [W-1:0]   res;
  logic           busy;
  logic [LW-1:0]  lat;
  logic [W-1:0]   inv_din, inv_mod;
  logic           inv_en;
  logic [W-1:0]   inv_res;
  logic           inv_vld;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: round-robin pointer, last result, last latency.
  int           ptr_m = 0;
  int           lat_m = 0;
  logic [W-1:0] res_m = '0;

  assign din = {op_v[3], op_v[2], op_v[1], op_v[0]};

  montinv_arb #(
    .WIDTH (W),
    .NREQ  (N),
    .IDXW  (IW),
    .LATW  (LW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .din     (din),
    .mod     (mod_r),
    .gnt     (gnt),
    .done    (done),
    .err     (err),
    .res     (res),
    .busy    (busy),
    .lat     (lat),
    .inv_din (inv_din),
    .inv_mod (inv_mod),
    .inv_en  (inv_en),
    .inv_res (inv_res),
    .inv_vld (inv_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int model_pick(input logic [N-1:0] m, input int p);
    for (int s = 0; s < N; s++) begin
      int j;
      j = (p + s) % N;
      if (m[j]) return j;
    end
    return 0;
  endfunction

  function automatic int model_inv(input int a, input int m);
    for (int x = 1; x < m; x++)
      if ((a * x) % m == 1) return x;
    return 0;
  endfunction

  task automatic check_reset_outputs();
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_res", res, 0);
    check("rst_inv_din", inv_din, 0);
    check("rst_inv_mod", inv_mod, 0);
    check("rst_lat", lat, 0);
    check("rst_inv_en", inv_en, 0);
    check("rst_busy", busy, 0);
  endtask

  task automatic tick_idle();
    tick();
    check("idle_busy", busy, 0);
    check("idle_gnt", gnt, 0);
    check("idle_done", done, 0);
    check("idle_res", res, res_m);
  endtask

  // Called at the negedge of an IDLE cycle with req already driven; returns at
  // the negedge of the response cycle, with the served requester dropped.
  task automatic serve(input int d, input logic [N-1:0] raise, output int k);
    int op;
    int expv;
    bit quiet;
    k     = model_pick(req, ptr_m);
    ptr_m = (k + 1) % N;
    op    = int'(op_v[k]);
    tick();
    check("gnt", gnt, 64'(1) << k);
    check("busy", busy, 1);
    check("inv_en_early", inv_en, 0);
    tick();
    if (op == 0 || op >= int'(mod_r)) begin
      check("err", err, 64'(1) << k);
      check("inv_en_illegal", inv_en, 0);
      check("done_illegal", done, 0);
      check("lat_kept", lat, lat_m);
      req[k] = 1'b0;
      return;
    end
    check("inv_en", inv_en, 1);
    check("inv_din", inv_din, op);
    check("inv_mod", inv_mod, mod_r);
    expv  = model_inv(op, int'(mod_r));
    quiet = 1'b1;
    for (int i = 1; i <= d; i++) begin
      tick();
      if (i == 1) req = req | raise;
      if (done != 0 || err != 0 || inv_en || !busy) quiet = 1'b0;
    end
    inv_vld = 1'b1;
    inv_res = W'(expv);
    tick();
    inv_vld = 1'b0;
    inv_res = W'($urandom);
    check("quiet_wait", quiet, 1);
    check("done", done, 64'(1) << k);
    check("err_clear", err, 0);
    check("res", res, expv);
    check("lat", lat, d);
    check("gnt_resp", gnt, 64'(1) << k);
    check("inv_din_hold", inv_din, op);
    req[k] = 1'b0;
    res_m  = W'(expv);
    lat_m  = d;
  endtask

  initial begin
    int k;
    int order [$];
    rst     = 1'b1;
    req     = '0;
    mod_r   = 8'd251;
    inv_vld = 1'b0;
    inv_res = '0;
    for (int i = 0; i < N; i++) op_v[i] = '0;

    tick();
    tick();
    check_reset_outputs();
    rst = 1'b0;
    tick_idle();

    // Single request: inverse of 2 mod 251 after 37 cycles.
    op_v[0] = 8'd2;
    req     = 4'b0001;
    serve(37, '0, k);
    tick_idle();
    check("single_busy_after", busy, 0);

    // Illegal operands on requester 1: zero, equal to modulus, above modulus.
    op_v[1] = 8'd0;
    req     = 4'b0010;
    serve(5, '0, k);
    tick_idle();
    op_v[1] = 8'd251;
    req     = 4'b0010;
    serve(5, '0, k);
    tick_idle();
    op_v[1] = 8'd255;
    req     = 4'b0010;
    serve(5, '0, k);
    tick_idle();
    check("lat_after_illegal", lat, 37);

    // Minimum latency and random masks / operands / latencies.
    op_v[2] = 8'd250;
    req     = 4'b0100;
    serve(1, '0, k);
    tick_idle();
    repeat (6) begin
      for (int i = 0; i < N; i++) op_v[i] = W'($urandom_range(1, 250));
      req = N'($urandom_range(1, 15));
      serve(int'($urandom_range(1, 20)), '0, k);
      tick_idle();
      req = '0;
    end

    // Fairness from a fresh pointer: all requesters keep re-requesting.
    rst = 1'b1;
    req = '0;
    tick();
    rst   = 1'b0;
    ptr_m = 0;
    lat_m = 0;
    res_m = '0;
    check_reset_outputs();
    tick_idle();
    for (int i = 0; i < N; i++) op_v[i] = W'($urandom_range(1, 250));
    req = '1;
    repeat (6) begin
      serve(int'($urandom_range(2, 8)), '0, k);
      order.push_back(k);
      tick_idle();
      req[k] = 1'b1;
    end
    for (int i = 0; i < 6; i++) check("fair_order", order[i], i % N);
    req = '0;
    tick_idle();

    // Wrap and skip: move pointer to 3, then serve 3, 1, and a late 2.
    req = 4'b0100;
    serve(3, '0, k);
    tick_idle();
    req = 4'b1010;
    serve(4, '0, k);
    check("wrap_first", k, 3);
    tick_idle();
    serve(6, 4'b0100, k);
    check("wrap_second", k, 1);
    tick_idle();
    serve(2, '0, k);
    check("late_req", k, 2);
    tick_idle();
    req = '0;

    // Reset ten cycles after launch: abort silently.
    op_v[0] = 8'd77;
    req     = 4'b0001;
    tick();
    check("abort_gnt", gnt, 4'b0001);
    tick();
    check("abort_inv_en", inv_en, 1);
    repeat (10) tick();
    rst = 1'b1;
    req = '0;
    tick();
    check_reset_outputs();
    rst   = 1'b0;
    ptr_m = 0;
    lat_m = 0;
    res_m = '0;
    tick_idle();
    inv_vld = 1'b1;
    inv_res = 8'h55;
    tick();
    inv_vld = 1'b0;
    check("stray_done", done, 0);
    tick_idle();
    check("stray_lat", lat, 0);

    // Fresh requester 2 after the abort, then a stray valid with a live result.
    op_v[2] = 8'd100;
    req     = 4'b0100;
    serve(11, '0, k);
    tick_idle();
    inv_vld = 1'b1;
    inv_res = 8'hA5;
    tick();
    inv_vld = 1'b0;
    check("stray2_done", done, 0);
    check("stray2_busy", busy, 0);
    tick_idle();
    check("stray2_lat", lat, 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
